multi_digit_timer: RTL and testbench

MULTI_DIGIT_TIMER -- requirements
Module: multi_digit_timer

---
 rtl/multi_digit_timer.sv | 227 ++++++++++++++++++++++
 tb/tb_multi_digit_timer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_digit_timer
// Description : Multi-digit BCD stopwatch / countdown timer with selectable
//               tick rate, pause/hold control and per-digit seven-segment
//               decode.
//
// Parameters  : DIGITS    number of BCD digits (2..6)
//               BASE_DIV  clk_50M cycles per 20 Hz base strobe
//
// Ports       : clk_50M     single rising-edge clock
//               rst         synchronous active-high reset
//               en          global enable; low freezes divider, state, digits
//               start_up    pulse: clear count and count up
//               start_down  pulse: load preset and count down
//               pause_tgl   pulse: toggle RUN/PAUSE
//               hold        level: blocks ticks while high
//               rate_sel    00=1 Hz, 01=2 Hz, 10=4 Hz, 11=10 Hz
//               preset      BCD preset, digit 0 in [3:0]
//               bcd         registered current count
//               seg         per-digit segments a..g, a at bit 6, active-high
//               running     high in RUN
//               done        high in DONE
//
// Build option: TIMER_ZERO_BLANK_EN blanks leading zero digits (digit 0 is
//               always shown).
//
// Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_timer #(
    parameter int DIGITS   = 3,
    parameter int BASE_DIV = 2500000
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start_up,
    input  logic                  start_down,
    input  logic                  pause_tgl,
    input  logic                  hold,
    input  logic [1:0]            rate_sel,
    input  logic [DIGITS*4-1:0]   preset,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [DIGITS*7-1:0]   seg,
    output logic                  running,
    output logic                  done
);

    localparam int DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(BASE_DIV - 1);
    localparam int BW = DIGITS * 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic             r_dir;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_sc;
    logic [1:0]       r_rate_prev;
    logic [BW-1:0]    r_bcd;

    logic [BW-1:0]    w_preset;
    logic [BW-1:0]    w_inc;
    logic [BW-1:0]    w_dec;
    logic [DIGITS:0]  w_carry;
    logic [DIGITS:0]  w_borrow;
    logic [4:0]       w_n_last;
    logic             w_active;
    logic             w_strobe;
    logic             w_rate_chg;
    logic             w_tick;

    // Preset sanitising plus ripple BCD increment/decrement of the count.
    always_comb begin
        w_preset    = '0;
        w_inc       = '0;
        w_dec       = '0;
        w_carry     = '0;
        w_borrow    = '0;
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_preset[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];

            if (w_carry[i]) begin
                w_inc[4*i +: 4] = (r_bcd[4*i +: 4] == 4'd9) ? 4'd0 : r_bcd[4*i +: 4] + 4'd1;
            end else begin
                w_inc[4*i +: 4] = r_bcd[4*i +: 4];
            end
            w_carry[i+1] = w_carry[i] && (r_bcd[4*i +: 4] == 4'd9);

            if (w_borrow[i]) begin
                w_dec[4*i +: 4] = (r_bcd[4*i +: 4] == 4'd0) ? 4'd9 : r_bcd[4*i +: 4] - 4'd1;
            end else begin
                w_dec[4*i +: 4] = r_bcd[4*i +: 4];
            end
            w_borrow[i+1] = w_borrow[i] && (r_bcd[4*i +: 4] == 4'd0);
        end
    end

    // Base strobes per tick, minus one.
    always_comb begin
        case (rate_sel)
            2'b00:   w_n_last = 5'd19;
            2'b01:   w_n_last = 5'd9;
            2'b10:   w_n_last = 5'd4;
            default: w_n_last = 5'd1;
        endcase
    end

    assign w_active   = en && (r_state == S_RUN) && !hold;
    assign w_strobe   = w_active && (r_div == C_DIV_LAST);
    assign w_rate_chg = (rate_sel != r_rate_prev);
    // A rate change restarts the strobe count, so it never completes a tick.
    assign w_tick     = w_strobe && (r_sc == w_n_last) && !w_rate_chg;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_div       <= '0;
            r_sc        <= '0;
            r_rate_prev <= rate_sel;
            r_bcd       <= '0;
        end else begin
            r_rate_prev <= rate_sel;
            if (en) begin
                if (start_down) begin
                    r_bcd   <= w_preset;
                    r_dir   <= 1'b1;
                    r_div   <= '0;
                    r_sc    <= '0;
                    r_state <= (w_preset == '0) ? S_DONE : S_RUN;
                end else if (start_up) begin
                    r_bcd   <= '0;
                    r_dir   <= 1'b0;
                    r_div   <= '0;
                    r_sc    <= '0;
                    r_state <= S_RUN;
                end else begin
                    if (pause_tgl) begin
                        if (r_state == S_RUN) begin
                            r_state <= S_PAUSE;
                        end else if (r_state == S_PAUSE) begin
                            r_state <= S_RUN;
                        end
                    end
                    // The divider still advances on the edge that pauses;
                    // a terminal tick on that edge overrides the pause.
                    if (w_active) begin
                        r_div <= (r_div == C_DIV_LAST) ? '0 : r_div + DIV_W'(1);
                        if (w_strobe) begin
                            r_sc <= (r_sc == w_n_last) ? 5'd0 : r_sc + 5'd1;
                        end
                        if (w_tick) begin
                            if (!r_dir) begin
                                if (w_carry[DIGITS]) begin
                                    // Wrap from all 9s: keep showing all 9s.
                                    r_state <= S_DONE;
                                end else begin
                                    r_bcd <= w_inc;
                                    if ((w_preset != '0) && (w_inc == w_preset)) begin
                                        r_state <= S_DONE;
                                    end
                                end
                            end else begin
                                r_bcd <= w_dec;
                                if (w_dec == '0) begin
                                    r_state <= S_DONE;
                                end
                            end
                        end
                    end
                end
            end
            if (w_rate_chg) begin
                r_sc <= '0;
            end
        end
    end

`ifdef TIMER_ZERO_BLANK_EN
    // w_lz[i]: digit i and every more significant digit are zero.
    logic [DIGITS:0] w_lz;
    always_comb begin
        w_lz         = '0;
        w_lz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_lz[i] = w_lz[i+1] && (r_bcd[4*i +: 4] == 4'd0);
        end
    end
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        logic [6:0] w_raw;
        always_comb begin
            case (r_bcd[4*g +: 4])
                4'd0:    w_raw = 7'b1111110;
                4'd1:    w_raw = 7'b0110000;
                4'd2:    w_raw = 7'b1101101;
                4'd3:    w_raw = 7'b1111001;
                4'd4:    w_raw = 7'b0110011;
                4'd5:    w_raw = 7'b1011011;
                4'd6:    w_raw = 7'b1011111;
                4'd7:    w_raw = 7'b1110000;
                4'd8:    w_raw = 7'b1111111;
                4'd9:    w_raw = 7'b1111011;
                default: w_raw = 7'b0000000;
            endcase
        end
`ifdef TIMER_ZERO_BLANK_EN
        assign seg[7*g +: 7] = ((g > 0) && w_lz[g]) ? 7'b0000000 : w_raw;
`else
        assign seg[7*g +: 7] = w_raw;
`endif
    end

    assign bcd     = r_bcd;
    assign running = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multi_digit_timer
// Description : Directed testbench for multi_digit_timer (DIGITS=2,
//               BASE_DIV=2). Expected outputs are queued with the cycle they
//               are due when stimulus is applied, then compared as the DUT
//               reaches that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_digit_timer;

    localparam int DIGITS   = 2;
    localparam int BASE_DIV = 2;

    logic                clk_50M;
    logic                rst;
    logic                en;
    logic                start_up;
    logic                start_down;
    logic                pause_tgl;
    logic                hold;
    logic [1:0]          rate_sel;
    logic [DIGITS*4-1:0] preset;
    logic [DIGITS*4-1:0] bcd;
    logic [DIGITS*7-1:0] seg;
    logic                running;
    logic                done;

    multi_digit_timer #(
        .DIGITS   (DIGITS),
        .BASE_DIV (BASE_DIV)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .en         (en),
        .start_up   (start_up),
        .start_down (start_down),
        .pause_tgl  (pause_tgl),
        .hold       (hold),
        .rate_sel   (rate_sel),
        .preset     (preset),
        .bcd        (bcd),
        .seg        (seg),
        .running    (running),
        .done       (done)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] bcd;
        logic       run;
        logic       dn;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   t0;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1111110;
            4'd1: s = 7'b0110000;
            4'd2: s = 7'b1101101;
            4'd3: s = 7'b1111001;
            4'd4: s = 7'b0110011;
            4'd5: s = 7'b1011011;
            4'd6: s = 7'b1011111;
            4'd7: s = 7'b1110000;
            4'd8: s = 7'b1111111;
            4'd9: s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    function automatic logic [13:0] exp_seg(input logic [7:0] b);
        logic [6:0] hi;
        hi = seg_of(b[7:4]);
`ifdef TIMER_ZERO_BLANK_EN
        if (b[7:4] == 4'd0) hi = 7'b0000000;
`endif
        return {hi, seg_of(b[3:0])};
    endfunction

    task automatic push_exp(input int due, input logic [7:0] b, input logic r,
                            input logic d, input string tag);
        exp_t e;
        e.due = due;
        e.bcd = b;
        e.run = r;
        e.dn  = d;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Advance one clock and compare every entry due at the new cycle.
    task automatic step();
        exp_t e;
        logic [13:0] es;
        @(posedge clk_50M);
        #1;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e  = sb.pop_front();
            es = exp_seg(e.bcd);
            checks++;
            assert (bcd === e.bcd) else begin
                failures++;
                $error("FAIL %s bcd cycle=%0d got=%h exp=%h", e.tag, cyc, bcd, e.bcd);
            end
            checks++;
            assert (running === e.run) else begin
                failures++;
                $error("FAIL %s running cycle=%0d got=%b exp=%b", e.tag, cyc, running, e.run);
            end
            checks++;
            assert (done === e.dn) else begin
                failures++;
                $error("FAIL %s done cycle=%0d got=%b exp=%b", e.tag, cyc, done, e.dn);
            end
            checks++;
            assert (seg === es) else begin
                failures++;
                $error("FAIL %s seg cycle=%0d got=%b exp=%b", e.tag, cyc, seg, es);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic up, input logic dn);
        start_up   = up;
        start_down = dn;
        step();
        start_up   = 1'b0;
        start_down = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        start_up   = 1'b0;
        start_down = 1'b0;
        pause_tgl  = 1'b0;
        hold       = 1'b0;
        rate_sel   = 2'b11;
        preset     = 8'h00;

        // Reset state
        push_exp(cyc + 1, 8'h00, 1'b0, 1'b0, "reset");
        push_exp(cyc + 2, 8'h00, 1'b0, 1'b0, "reset2");
        run(2);
        rst = 1'b0;
        run(2);

        // Count up from 00 to 99, then wrap into DONE holding 99
        t0 = cyc + 1;
        push_exp(t0 + 3, 8'h00, 1'b1, 1'b0, "up_latency");
        for (int k = 1; k <= 99; k++) push_exp(t0 + 4*k, to_bcd(k), 1'b1, 1'b0, "up_count");
        push_exp(t0 + 400, 8'h99, 1'b0, 1'b1, "up_wrap");
        push_exp(t0 + 404, 8'h99, 1'b0, 1'b1, "up_wrap_hold");
        pulse(1'b1, 1'b0);
        run(404);

        // Count down from 12 to 00
        preset = 8'h12;
        t0 = cyc + 1;
        push_exp(t0, 8'h12, 1'b1, 1'b0, "down_load");
        for (int k = 1; k <= 12; k++)
            push_exp(t0 + 4*k, to_bcd(12 - k), (k < 12), (k == 12), "down_count");
        push_exp(t0 + 52, 8'h00, 1'b0, 1'b1, "down_done_hold");
        pulse(1'b0, 1'b1);
        run(52);

        // Zero preset countdown goes straight to DONE; pause ignored in DONE
        preset = 8'h00;
        t0 = cyc + 1;
        push_exp(t0, 8'h00, 1'b0, 1'b1, "down_zero");
        push_exp(t0 + 2, 8'h00, 1'b0, 1'b1, "pause_in_done");
        pulse(1'b0, 1'b1);
        run(1);
        pause_tgl = 1'b1;
        step();
        pause_tgl = 1'b0;

        // Count up stops on a nonzero preset
        preset = 8'h03;
        t0 = cyc + 1;
        push_exp(t0 + 8, 8'h02, 1'b1, 1'b0, "up_preset_mid");
        push_exp(t0 + 12, 8'h03, 1'b0, 1'b1, "up_preset_done");
        push_exp(t0 + 20, 8'h03, 1'b0, 1'b1, "up_preset_hold");
        pulse(1'b1, 1'b0);
        run(20);

        // Non-BCD preset nibble is treated as 9
        preset = 8'h1F;
        t0 = cyc + 1;
        push_exp(t0, 8'h19, 1'b1, 1'b0, "nonbcd_load");
        push_exp(t0 + 4, 8'h18, 1'b1, 1'b0, "nonbcd_dec");
        pulse(1'b0, 1'b1);
        run(4);

        // Pause at cycle 5, resume at cycle 25
        preset = 8'h00;
        t0 = cyc + 1;
        push_exp(t0 + 4, 8'h01, 1'b1, 1'b0, "pause_pre");
        push_exp(t0 + 5, 8'h01, 1'b0, 1'b0, "paused");
        push_exp(t0 + 24, 8'h01, 1'b0, 1'b0, "paused_end");
        push_exp(t0 + 25, 8'h01, 1'b1, 1'b0, "resumed");
        push_exp(t0 + 27, 8'h01, 1'b1, 1'b0, "resume_pre");
        push_exp(t0 + 28, 8'h02, 1'b1, 1'b0, "resume_tick");
        pulse(1'b1, 1'b0);
        run(4);
        pause_tgl = 1'b1;
        step();
        pause_tgl = 1'b0;
        run(19);
        pause_tgl = 1'b1;
        step();
        pause_tgl = 1'b0;
        run(4);

        // hold blocks counting for 10 cycles
        t0 = cyc + 1;
        push_exp(t0 + 13, 8'h00, 1'b1, 1'b0, "hold_pre");
        push_exp(t0 + 14, 8'h01, 1'b1, 1'b0, "hold_tick");
        pulse(1'b1, 1'b0);
        hold = 1'b1;
        run(10);
        hold = 1'b0;
        run(4);

        // en low freezes for 3 cycles
        t0 = cyc + 1;
        push_exp(t0 + 6, 8'h00, 1'b1, 1'b0, "en_pre");
        push_exp(t0 + 7, 8'h01, 1'b1, 1'b0, "en_tick");
        pulse(1'b1, 1'b0);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(4);

        // 1 Hz rate: 20 base strobes per tick
        rate_sel = 2'b00;
        t0 = cyc + 1;
        push_exp(t0 + 39, 8'h00, 1'b1, 1'b0, "rate1_pre");
        push_exp(t0 + 40, 8'h01, 1'b1, 1'b0, "rate1_tick");
        pulse(1'b1, 1'b0);
        run(40);

        // Rate change mid-count restarts the strobe count only
        rate_sel = 2'b11;
        t0 = cyc + 1;
        push_exp(t0 + 11, 8'h00, 1'b1, 1'b0, "ratechg_pre");
        push_exp(t0 + 12, 8'h01, 1'b1, 1'b0, "ratechg_tick");
        pulse(1'b1, 1'b0);
        run(2);
        rate_sel = 2'b10;
        run(10);

        // Simultaneous starts: down wins; rst aborts and discards a start
        rate_sel = 2'b11;
        preset   = 8'h05;
        t0 = cyc + 1;
        push_exp(t0, 8'h05, 1'b1, 1'b0, "both_start");
        push_exp(t0 + 4, 8'h04, 1'b1, 1'b0, "both_dec");
        push_exp(t0 + 7, 8'h00, 1'b0, 1'b0, "rst_abort");
        push_exp(t0 + 8, 8'h00, 1'b0, 1'b0, "rst_idle");
        pulse(1'b1, 1'b1);
        run(6);
        rst      = 1'b1;
        start_up = 1'b1;
        step();
        rst      = 1'b0;
        start_up = 1'b0;
        step();

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
